// File: rtl/sync_fifo_v2_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_v2_if
// Bus bundle for sync_fifo_v2: write side, read side, occupancy/threshold
// status and the sticky error flags with their clear. The producer/consumer
// side uses the master modport, the FIFO itself uses the slave modport.
// ---------------------------------------------------------------------------
interface sync_fifo_v2_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   // control
   logic             flush;
   logic             clr_err;

   // write side
   logic             w_en;
   logic [WIDTH-1:0] data_in;
   logic             full;
   logic             almost_full;

   // read side
   logic             r_en;
   logic [WIDTH-1:0] data_out;
   logic             rd_valid;
   logic             empty;
   logic             almost_empty;

   // status
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush,
      output clr_err,
      output w_en,
      output data_in,
      output r_en,
      input  full,
      input  almost_full,
      input  data_out,
      input  rd_valid,
      input  empty,
      input  almost_empty,
      input  count,
      input  overflow,
      input  underflow
   );

   modport slave (
      input  flush,
      input  clr_err,
      input  w_en,
      input  data_in,
      input  r_en,
      output full,
      output almost_full,
      output data_out,
      output rd_valid,
      output empty,
      output almost_empty,
      output count,
      output overflow,
      output underflow
   );
endinterface

// File: rtl/sync_fifo_v2.sv
// ---------------------------------------------------------------------------
// sync_fifo_v2
// Single-clock FIFO using all DEPTH entries (any DEPTH >= 2), with a
// registered occupancy count, programmable almost-full/almost-empty levels,
// selectable registered or first-word-fall-through read, synchronous flush
// and sticky overflow/underflow flags.
// Per-cycle priority: rst > flush > read/write.
// ---------------------------------------------------------------------------
module sync_fifo_v2 #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic          clk,
   input  logic          rst,
   sync_fifo_v2_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

   // Pointer increment with explicit wrap so non-power-of-2 depths use
   // exactly DEPTH slots.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == PTR_LAST) begin
         n = {PW{1'b0}};
      end else begin
         n = p + PW'(1'b1);
      end
      return n;
   endfunction

   // Status flags derived from an occupancy value: {full, af, empty, ae}.
   // Shared by the next-state path and reset so both agree by construction.
   function automatic logic [3:0] flags_of(input logic [CW-1:0] c);
      logic [3:0] f;
      f[3] = (c == CNT_FULL);
      f[2] = (c >= AF_LVL);
      f[1] = (c == {CW{1'b0}});
      f[0] = (c <= AE_LVL);
      return f;
   endfunction

   // storage (not reset)
   logic [WIDTH-1:0] mem_q [DEPTH];

   // state
   logic [PW-1:0] w_ptr_q,        w_ptr_d;
   logic [PW-1:0] r_ptr_q,        r_ptr_d;
   logic [CW-1:0] count_q,        count_d;
   logic          full_q,         full_d;
   logic          almost_full_q,  almost_full_d;
   logic          empty_q,        empty_d;
   logic          almost_empty_q, almost_empty_d;
   logic          overflow_q,     overflow_d;
   logic          underflow_q,    underflow_d;

   // decoded per-cycle events
   logic wr_acc_s;
   logic rd_acc_s;
   logic ovf_evt_s;
   logic unf_evt_s;

   // Accept decisions: flush masks both requests; full/empty gate them, so a
   // full FIFO never writes through and an empty FIFO never bypasses.
   always_comb begin
      wr_acc_s  = 1'b0;
      rd_acc_s  = 1'b0;
      ovf_evt_s = 1'b0;
      unf_evt_s = 1'b0;
      if (bus.flush) begin
         wr_acc_s  = 1'b0;
         rd_acc_s  = 1'b0;
         ovf_evt_s = 1'b0;
         unf_evt_s = 1'b0;
      end else begin
         wr_acc_s  = bus.w_en & ~full_q;
         rd_acc_s  = bus.r_en & ~empty_q;
         ovf_evt_s = bus.w_en &  full_q;
         unf_evt_s = bus.r_en &  empty_q;
      end
   end

   // Next pointers, occupancy and the flags registered from next occupancy.
   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      if (bus.flush) begin
         w_ptr_d = {PW{1'b0}};
         r_ptr_d = {PW{1'b0}};
         count_d = {CW{1'b0}};
      end else begin
         if (wr_acc_s) begin
            w_ptr_d = ptr_inc(w_ptr_q);
         end else begin
            w_ptr_d = w_ptr_q;
         end
         if (rd_acc_s) begin
            r_ptr_d = ptr_inc(r_ptr_q);
         end else begin
            r_ptr_d = r_ptr_q;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
      {full_d, almost_full_d, empty_d, almost_empty_d} = flags_of(count_d);
   end

   // Sticky error flags: a new event wins over a coincident clear.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (ovf_evt_s) begin
         overflow_d = 1'b1;
      end else if (bus.clr_err) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      if (unf_evt_s) begin
         underflow_d = 1'b1;
      end else if (bus.clr_err) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // Control/status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr_q        <= {PW{1'b0}};
         r_ptr_q        <= {PW{1'b0}};
         count_q        <= {CW{1'b0}};
         {full_q, almost_full_q, empty_q, almost_empty_q} <= flags_of({CW{1'b0}});
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         w_ptr_q        <= w_ptr_d;
         r_ptr_q        <= r_ptr_d;
         count_q        <= count_d;
         full_q         <= full_d;
         almost_full_q  <= almost_full_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc_s) begin
         mem_q[w_ptr_q] <= bus.data_in;
      end
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [WIDTH-1:0] data_q, data_d;
         logic             rd_valid_q, rd_valid_d;

         // Registered read: load the head word on an accepted pop, else hold.
         always_comb begin
            data_d     = data_q;
            rd_valid_d = 1'b0;
            if (rd_acc_s) begin
               data_d     = mem_q[r_ptr_q];
               rd_valid_d = 1'b1;
            end else begin
               data_d     = data_q;
               rd_valid_d = 1'b0;
            end
         end

         // Read data/valid registers.
         always_ff @(posedge clk) begin
            if (rst) begin
               data_q     <= {WIDTH{1'b0}};
               rd_valid_q <= 1'b0;
            end else begin
               data_q     <= data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign bus.data_out = data_q;
         assign bus.rd_valid = rd_valid_q;
      end else begin : g_fwft_read
         // Head word presented directly; forced to zero while empty so the
         // output never carries stale or unreset storage.
         assign bus.data_out = empty_q ? {WIDTH{1'b0}} : mem_q[r_ptr_q];
         assign bus.rd_valid = ~empty_q;
      end
   endgenerate

   assign bus.full         = full_q;
   assign bus.almost_full  = almost_full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_empty = almost_empty_q;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_v2
// Directed bench for sync_fifo_v2 with three instances: DEPTH=8 registered
// read, DEPTH=6 registered read, DEPTH=8 FWFT. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sync_fifo_v2;
   logic clk = 1'b0;
   logic rst;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sync_fifo_v2_if #(.WIDTH(16), .DEPTH(8)) if_d8 ();
   sync_fifo_v2_if #(.WIDTH(16), .DEPTH(6)) if_d6 ();
   sync_fifo_v2_if #(.WIDTH(16), .DEPTH(8)) if_fw ();

   sync_fifo_v2 #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u_d8 (.clk(clk), .rst(rst), .bus(if_d8.slave));
   sync_fifo_v2 #(.WIDTH(16), .DEPTH(6), .FWFT(0)) u_d6 (.clk(clk), .rst(rst), .bus(if_d6.slave));
   sync_fifo_v2 #(.WIDTH(16), .DEPTH(8), .FWFT(1)) u_fw (.clk(clk), .rst(rst), .bus(if_fw.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      if_d8.flush = 1'b0; if_d8.clr_err = 1'b0; if_d8.w_en = 1'b0; if_d8.r_en = 1'b0; if_d8.data_in = 16'h0000;
      if_d6.flush = 1'b0; if_d6.clr_err = 1'b0; if_d6.w_en = 1'b0; if_d6.r_en = 1'b0; if_d6.data_in = 16'h0000;
      if_fw.flush = 1'b0; if_fw.clr_err = 1'b0; if_fw.w_en = 1'b0; if_fw.r_en = 1'b0; if_fw.data_in = 16'h0000;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_all();
      tick();
      tick();
      n_checks++; if (if_d8.count !== 4'd0)        begin n_fail++; $display("FAIL rst_count: got %0d expected 0", if_d8.count); end
      n_checks++; if (if_d8.empty !== 1'b1)        begin n_fail++; $display("FAIL rst_empty: got %b expected 1", if_d8.empty); end
      n_checks++; if (if_d8.full !== 1'b0)         begin n_fail++; $display("FAIL rst_full: got %b expected 0", if_d8.full); end
      n_checks++; if (if_d8.almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_ae: got %b expected 1", if_d8.almost_empty); end
      n_checks++; if (if_d8.almost_full !== 1'b0)  begin n_fail++; $display("FAIL rst_af: got %b expected 0", if_d8.almost_full); end
      n_checks++; if (if_d8.data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h expected 0000", if_d8.data_out); end
      n_checks++; if (if_d8.rd_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_rd_valid: got %b expected 0", if_d8.rd_valid); end
      n_checks++; if (if_d8.overflow !== 1'b0 || if_d8.underflow !== 1'b0) begin n_fail++; $display("FAIL rst_err: got ovf=%b unf=%b expected 0 0", if_d8.overflow, if_d8.underflow); end
      n_checks++; if (if_fw.rd_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_fw_valid: got %b expected 0", if_fw.rd_valid); end
      n_checks++; if (if_d6.empty !== 1'b1)        begin n_fail++; $display("FAIL rst_d6_empty: got %b expected 1", if_d6.empty); end
      rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 8; i++) begin
         if_d8.w_en = 1'b1; if_d8.data_in = 16'(i);
         tick();
         n_checks++; if (if_d8.count !== 4'(i))               begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, if_d8.count, i); end
         n_checks++; if (if_d8.full !== (i == 8))             begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, if_d8.full, (i == 8)); end
         n_checks++; if (if_d8.almost_full !== (i >= 7))      begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, if_d8.almost_full, (i >= 7)); end
         n_checks++; if (if_d8.almost_empty !== (i <= 1))     begin n_fail++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, if_d8.almost_empty, (i <= 1)); end
         n_checks++; if (if_d8.empty !== 1'b0)                begin n_fail++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, if_d8.empty); end
      end
      if_d8.w_en = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if_d8.r_en = 1'b1;
         tick();
         n_checks++; if (if_d8.data_out !== 16'(i))           begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, if_d8.data_out, 16'(i)); end
         n_checks++; if (if_d8.rd_valid !== 1'b1)             begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, if_d8.rd_valid); end
         n_checks++; if (if_d8.count !== 4'(8 - i))           begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, if_d8.count, 8 - i); end
         n_checks++; if (if_d8.empty !== (i == 8))            begin n_fail++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, if_d8.empty, (i == 8)); end
      end
      if_d8.r_en = 1'b0;
      tick();
      n_checks++; if (if_d8.rd_valid !== 1'b0)     begin n_fail++; $display("FAIL drain_idle_valid: got %b expected 0", if_d8.rd_valid); end
      n_checks++; if (if_d8.data_out !== 16'h0008) begin n_fail++; $display("FAIL drain_idle_hold: got %h expected 0008", if_d8.data_out); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 8; i++) begin
         if_d8.w_en = 1'b1; if_d8.data_in = 16'h0100 + 16'(i);
         tick();
      end
      if_d8.data_in = 16'hDEAD;
      tick();
      if_d8.w_en = 1'b0;
      n_checks++; if (if_d8.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", if_d8.overflow); end
      n_checks++; if (if_d8.count !== 4'd8)    begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", if_d8.count); end
      // read and write together while full: only the read is taken
      if_d8.w_en = 1'b1; if_d8.r_en = 1'b1; if_d8.data_in = 16'hBEEF;
      tick();
      if_d8.w_en = 1'b0;
      n_checks++; if (if_d8.count !== 4'd7)        begin n_fail++; $display("FAIL full_rw_count: got %0d expected 7", if_d8.count); end
      n_checks++; if (if_d8.data_out !== 16'h0101) begin n_fail++; $display("FAIL full_rw_data: got %h expected 0101", if_d8.data_out); end
      for (int i = 2; i <= 8; i++) begin
         tick();
         n_checks++; if (if_d8.data_out !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL ovf_readback[%0d]: got %h expected %h", i, if_d8.data_out, 16'h0100 + 16'(i)); end
      end
      n_checks++; if (if_d8.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained_empty: got %b expected 1", if_d8.empty); end
      // r_en is still high on an empty FIFO: underflow
      tick();
      n_checks++; if (if_d8.underflow !== 1'b1 || if_d8.overflow !== 1'b1) begin n_fail++; $display("FAIL unf_set: got unf=%b ovf=%b expected 1 1", if_d8.underflow, if_d8.overflow); end
      // clear coincident with a fresh underflow: underflow stays, overflow clears
      if_d8.clr_err = 1'b1;
      tick();
      n_checks++; if (if_d8.underflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_event_unf: got %b expected 1", if_d8.underflow); end
      n_checks++; if (if_d8.overflow !== 1'b0)  begin n_fail++; $display("FAIL clr_ovf: got %b expected 0", if_d8.overflow); end
      if_d8.r_en = 1'b0;
      tick();
      if_d8.clr_err = 1'b0;
      n_checks++; if (if_d8.underflow !== 1'b0) begin n_fail++; $display("FAIL clr_unf: got %b expected 0", if_d8.underflow); end
   endtask

   task automatic test_wrap_d6();
      for (int k = 1; k <= 3; k++) begin
         if_d6.w_en = 1'b1; if_d6.data_in = 16'h0600 + 16'(k);
         tick();
      end
      n_checks++; if (if_d6.count !== 3'd3) begin n_fail++; $display("FAIL d6_preload: got %0d expected 3", if_d6.count); end
      for (int c = 0; c < 20; c++) begin
         if_d6.w_en = 1'b1; if_d6.r_en = 1'b1; if_d6.data_in = 16'h0600 + 16'(c + 4);
         tick();
         n_checks++; if (if_d6.count !== 3'd3)                  begin n_fail++; $display("FAIL d6_count[%0d]: got %0d expected 3", c, if_d6.count); end
         n_checks++; if (if_d6.data_out !== 16'h0600 + 16'(c + 1)) begin n_fail++; $display("FAIL d6_data[%0d]: got %h expected %h", c, if_d6.data_out, 16'h0600 + 16'(c + 1)); end
         n_checks++; if (if_d6.rd_valid !== 1'b1 || if_d6.full !== 1'b0 || if_d6.empty !== 1'b0) begin n_fail++; $display("FAIL d6_flags[%0d]: got v=%b f=%b e=%b expected 1 0 0", c, if_d6.rd_valid, if_d6.full, if_d6.empty); end
      end
      if_d6.w_en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         n_checks++; if (if_d6.data_out !== 16'h0600 + 16'(21 + j)) begin n_fail++; $display("FAIL d6_tail[%0d]: got %h expected %h", j, if_d6.data_out, 16'h0600 + 16'(21 + j)); end
      end
      if_d6.r_en = 1'b0;
      n_checks++; if (if_d6.empty !== 1'b1 || if_d6.underflow !== 1'b0) begin n_fail++; $display("FAIL d6_end: got e=%b unf=%b expected 1 0", if_d6.empty, if_d6.underflow); end
   endtask

   task automatic test_fwft();
      if_fw.w_en = 1'b1; if_fw.data_in = 16'h00AA;
      tick();
      if_fw.w_en = 1'b0;
      n_checks++; if (if_fw.data_out !== 16'h00AA || if_fw.rd_valid !== 1'b1) begin n_fail++; $display("FAIL fw_first: got %h v=%b expected 00aa 1", if_fw.data_out, if_fw.rd_valid); end
      tick();
      n_checks++; if (if_fw.data_out !== 16'h00AA || if_fw.count !== 4'd1) begin n_fail++; $display("FAIL fw_hold: got %h cnt=%0d expected 00aa 1", if_fw.data_out, if_fw.count); end
      if_fw.r_en = 1'b1;
      tick();
      if_fw.r_en = 1'b0;
      n_checks++; if (if_fw.empty !== 1'b1 || if_fw.rd_valid !== 1'b0) begin n_fail++; $display("FAIL fw_pop: got e=%b v=%b expected 1 0", if_fw.empty, if_fw.rd_valid); end
      if_fw.w_en = 1'b1; if_fw.data_in = 16'h00BB;
      tick();
      if_fw.data_in = 16'h00CC;
      tick();
      if_fw.w_en = 1'b0;
      n_checks++; if (if_fw.data_out !== 16'h00BB) begin n_fail++; $display("FAIL fw_head: got %h expected 00bb", if_fw.data_out); end
      if_fw.r_en = 1'b1;
      tick();
      n_checks++; if (if_fw.data_out !== 16'h00CC || if_fw.count !== 4'd1) begin n_fail++; $display("FAIL fw_next: got %h cnt=%0d expected 00cc 1", if_fw.data_out, if_fw.count); end
      tick();
      if_fw.r_en = 1'b0;
      n_checks++; if (if_fw.empty !== 1'b1 || if_fw.underflow !== 1'b0) begin n_fail++; $display("FAIL fw_end: got e=%b unf=%b expected 1 0", if_fw.empty, if_fw.underflow); end
   endtask

   task automatic test_underflow_flush();
      if_d8.r_en = 1'b1;
      tick();
      if_d8.r_en = 1'b0;
      n_checks++; if (if_d8.underflow !== 1'b1 || if_d8.count !== 4'd0 || if_d8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_read: got unf=%b cnt=%0d v=%b expected 1 0 0", if_d8.underflow, if_d8.count, if_d8.rd_valid); end
      n_checks++; if (if_d8.data_out !== 16'h0108) begin n_fail++; $display("FAIL empty_read_hold: got %h expected 0108", if_d8.data_out); end
      if_d8.clr_err = 1'b1;
      tick();
      if_d8.clr_err = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if_d8.w_en = 1'b1; if_d8.data_in = 16'h0500 + 16'(i);
         tick();
      end
      n_checks++; if (if_d8.count !== 4'd5) begin n_fail++; $display("FAIL pre_flush_count: got %0d expected 5", if_d8.count); end
      if_d8.flush = 1'b1; if_d8.w_en = 1'b1; if_d8.r_en = 1'b1; if_d8.data_in = 16'hBEEF;
      tick();
      if_d8.flush = 1'b0; if_d8.w_en = 1'b0; if_d8.r_en = 1'b0;
      n_checks++; if (if_d8.count !== 4'd0 || if_d8.empty !== 1'b1 || if_d8.almost_empty !== 1'b1) begin n_fail++; $display("FAIL flush_state: got cnt=%0d e=%b ae=%b expected 0 1 1", if_d8.count, if_d8.empty, if_d8.almost_empty); end
      n_checks++; if (if_d8.overflow !== 1'b0 || if_d8.underflow !== 1'b0) begin n_fail++; $display("FAIL flush_err: got ovf=%b unf=%b expected 0 0", if_d8.overflow, if_d8.underflow); end
      n_checks++; if (if_d8.rd_valid !== 1'b0 || if_d8.data_out !== 16'h0108) begin n_fail++; $display("FAIL flush_out: got v=%b d=%h expected 0 0108", if_d8.rd_valid, if_d8.data_out); end
      if_d8.w_en = 1'b1; if_d8.data_in = 16'h0777;
      tick();
      if_d8.w_en = 1'b0; if_d8.r_en = 1'b1;
      tick();
      if_d8.r_en = 1'b0;
      n_checks++; if (if_d8.data_out !== 16'h0777 || if_d8.count !== 4'd0) begin n_fail++; $display("FAIL post_flush: got %h cnt=%0d expected 0777 0", if_d8.data_out, if_d8.count); end
   endtask

   task automatic test_reset_mid();
      if_d8.r_en = 1'b1;
      tick();
      if_d8.r_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if_d8.w_en = 1'b1; if_d8.data_in = 16'h0400 + 16'(i);
         tick();
      end
      n_checks++; if (if_d8.count !== 4'd4 || if_d8.underflow !== 1'b1) begin n_fail++; $display("FAIL pre_rst: got cnt=%0d unf=%b expected 4 1", if_d8.count, if_d8.underflow); end
      if_d8.w_en = 1'b1; if_d8.r_en = 1'b1; if_d8.data_in = 16'h0999; rst = 1'b1;
      tick();
      rst = 1'b0; if_d8.w_en = 1'b0; if_d8.r_en = 1'b0;
      n_checks++; if (if_d8.count !== 4'd0 || if_d8.empty !== 1'b1 || if_d8.full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_occ: got cnt=%0d e=%b f=%b expected 0 1 0", if_d8.count, if_d8.empty, if_d8.full); end
      n_checks++; if (if_d8.almost_empty !== 1'b1 || if_d8.almost_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_thr: got ae=%b af=%b expected 1 0", if_d8.almost_empty, if_d8.almost_full); end
      n_checks++; if (if_d8.data_out !== 16'h0000 || if_d8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got %h v=%b expected 0000 0", if_d8.data_out, if_d8.rd_valid); end
      n_checks++; if (if_d8.underflow !== 1'b0 || if_d8.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got unf=%b ovf=%b expected 0 0", if_d8.underflow, if_d8.overflow); end
      if_d8.r_en = 1'b1;
      tick();
      if_d8.r_en = 1'b0;
      n_checks++; if (if_d8.underflow !== 1'b1 || if_d8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_read: got unf=%b v=%b expected 1 0", if_d8.underflow, if_d8.rd_valid); end
      if_d8.clr_err = 1'b1; if_d8.w_en = 1'b1; if_d8.data_in = 16'h1234;
      tick();
      if_d8.clr_err = 1'b0; if_d8.w_en = 1'b0; if_d8.r_en = 1'b1;
      tick();
      if_d8.r_en = 1'b0;
      n_checks++; if (if_d8.data_out !== 16'h1234 || if_d8.rd_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_data: got %h v=%b expected 1234 1", if_d8.data_out, if_d8.rd_valid); end
      n_checks++; if (if_d8.underflow !== 1'b0 || if_d8.empty !== 1'b1) begin n_fail++; $display("FAIL post_rst_end: got unf=%b e=%b expected 0 1", if_d8.underflow, if_d8.empty); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_wrap_d6();
      test_fwft();
      test_underflow_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
Parametrised single-clock FIFO, successor to the team's basic sync FIFO, used between systolic-array feeder/drain stages and the host-side buffers.
Adds:
- Full use of all DEPTH entries, including non-power-of-2 depths.
- Occupancy count and programmable almost-full/almost-empty thresholds.
- Selectable first-word-fall-through (FWFT) read mode.
- Synchronous flush and sticky overflow/underflow error flags.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, power of 2 not required)
FWFT, 0, 0 = registered read (data one cycle after r_en), 1 = first-word-fall-through
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
CW, $clog2(DEPTH+1), derived count width; not overridden by users

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of contents
w_en  in  1  write request
data_in  in  WIDTH  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
r_en  in  1  read/pop request
data_out  out  WIDTH  read data
rd_valid  out  1  data_out holds valid read data
empty  out  1  count == 0
almost_empty  out  1  count <= AE_LEVEL
count  out  CW  current occupancy 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Single clock, synchronous active-high reset (rst); everything is sampled on the rising edge of clk.
- Reset values: w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), data_out=0, rd_valid=0, overflow=0, underflow=0. Storage contents are not reset.
- Priority per cycle: rst > flush > read/write.
  - flush: pointers and count go to 0, rd_valid goes to 0, data_out holds its value, error flags are unchanged.
  - A w_en or r_en coincident with flush is ignored and does not set error flags.
- Write accepted iff w_en && !full.
  - Accepted write stores data_in at w_ptr; w_ptr advances, wrapping DEPTH-1 -> 0.
  - A write while full is dropped and sets overflow.
- Read accepted iff r_en && !empty.
  - Accepted read advances r_ptr with the same wrap rule.
  - A read while empty sets underflow; pointers, data_out and count are unchanged.
- Simultaneous accepted read and write: count unchanged.
  - When full, only the read is accepted (no write-through); the write sets overflow.
  - When empty, only the write is accepted (no bypass); the read sets underflow.
- count is registered: +1 on write only, -1 on read only, otherwise held.
- full, empty, almost_full and almost_empty are registered from next-count, so they change in the same cycle as count.
- FWFT=0 (registered read):
  - An accepted read in cycle N loads mem[r_ptr] into data_out, visible in cycle N+1, with rd_valid=1 for exactly that cycle.
  - Otherwise rd_valid=0 and data_out holds its last value.
- FWFT=1:
  - data_out = mem[r_ptr] combinationally; rd_valid = !empty.
  - r_en acts as a pop/acknowledge.
  - A write into an empty FIFO is visible on data_out, with rd_valid=1, one cycle after the write edge.
  - When empty, data_out is don't-care.
- overflow and underflow are sticky until rst or clr_err.
  - If clr_err coincides with a new error event, the flag stays set.
- Reset mid-operation discards all contents; the first read after reset sees empty=1.
- Latency: write-to-not-empty is 1 cycle. Read-to-data is 1 cycle (FWFT=0) or 0 cycles (FWFT=1).

Test Plan:
1. DEPTH=8, FWFT=0. Write 0x0001..0x0008 on 8 consecutive cycles -> count increments 1..8, full=1 after the 8th edge, almost_full=1 from count=7. Then read 8 times -> data_out 0x0001..0x0008, each one cycle after its r_en, rd_valid pulses each cycle; empty=1 after the 8th read.
2. Full FIFO (count=8): w_en=1 with 0xDEAD -> dropped, overflow=1, count stays 8; reading back shows no 0xDEAD. Then clr_err=1 -> overflow=0.
3. DEPTH=6 (non-power-of-2). 20 cycles of simultaneous write and read, after 3 pre-loaded words -> count stays 3 throughout, pointers wrap 5->0, data emerges in order with no loss or duplication.
4. FWFT=1. Write 0x00AA into an empty FIFO -> next cycle data_out=0x00AA, rd_valid=1 with no r_en. Then r_en=1 -> empty=1 next cycle.
5. Empty FIFO: r_en=1 -> underflow=1, count=0, rd_valid=0. With 5 words stored, assert flush together with w_en -> count=0, empty=1, no write stored, no flag set.
6. rst asserted while count=4 with w_en and r_en active -> all outputs at their reset values next cycle; subsequent behaviour matches a fresh FIFO.
